// File: rtl/debounce_pkg.sv
// Shared state encodings and synchronizer depth for the input debouncer.
package debounce_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      S_LOW      = 2'b00,
      S_CHK_HIGH = 2'b01,
      S_HIGH     = 2'b11,
      S_CHK_LOW  = 2'b10
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff
   import debounce_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stg <= '0;
      else      stg <= {stg[SYNC_STAGES-2:0], d};
   end

   assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Switch/pin debouncer: 2-flop sync, then a qualify-before-accept FSM.
// Define INPUT_DEBOUNCE_EDGE_EN to build the rise/fall pulse outputs.
module input_debounce
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic qb,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             d_sync;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             q_nxt;
   logic             busy_nxt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (d_sync)
   );

   // Any disagreement during a check state drops back and forfeits the count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_LOW: begin
            if (d_sync) begin
               state_nxt = S_CHK_HIGH;
               cnt_nxt   = '0;
            end
         end
         S_CHK_HIGH: begin
            if (!d_sync) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!d_sync) begin
               state_nxt = S_CHK_LOW;
               cnt_nxt   = '0;
            end
         end
         S_CHK_LOW: begin
            if (d_sync) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
         end
      endcase
      q_nxt    = (state_nxt == S_HIGH) || (state_nxt == S_CHK_LOW);
      busy_nxt = (state_nxt == S_CHK_HIGH) || (state_nxt == S_CHK_LOW);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_LOW;
         cnt   <= '0;
         q     <= 1'b0;
         qb    <= 1'b1;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         q     <= q_nxt;
         qb    <= ~q_nxt;
         busy  <= busy_nxt;
      end
   end

`ifdef INPUT_DEBOUNCE_EDGE_EN
   // Pulses are registered alongside q so they coincide with its edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= (state == S_CHK_HIGH) && (state_nxt == S_HIGH);
         fall <= (state == S_CHK_LOW)  && (state_nxt == S_LOW);
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: run-length reference model plus directed literal checkpoints.
module tb_input_debounce;

   localparam int unsigned STABLE = 4;
   localparam int unsigned CNT_W  = 8;
`ifdef INPUT_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic din;
   logic q, qb, rise, fall, busy;

   int n_cmp = 0;
   int n_bad = 0;

   input_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .q    (q),
      .qb   (qb),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   always #10 clk = ~clk;

   // Reference: the level seen two samples late must disagree with q for
   // STABLE+1 consecutive edges before q flips; any agreement clears the run.
   logic [1:0] hist;
   logic       m_q, m_rise, m_fall, m_busy;
   int         run;

   function automatic int next_run(input logic seen, input logic cur_q, input int r);
      return (seen != cur_q) ? r + 1 : 0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist   <= 2'b00;
         m_q    <= 1'b0;
         m_rise <= 1'b0;
         m_fall <= 1'b0;
         m_busy <= 1'b0;
         run    <= 0;
      end else begin
         hist   <= {hist[0], din};
         if (next_run(hist[1], m_q, run) == int'(STABLE) + 1) begin
            m_q    <= ~m_q;
            m_rise <= EDGE_EN & ~m_q;
            m_fall <= EDGE_EN & m_q;
            m_busy <= 1'b0;
            run    <= 0;
         end else begin
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            m_busy <= (next_run(hist[1], m_q, run) > 0);
            run    <= next_run(hist[1], m_q, run);
         end
      end
   end

   // Hand-computed expectations for directed phases, set before each edge.
   logic lit_on = 1'b0;
   logic lit_q, lit_busy, lit_rise, lit_fall;

   task automatic chk(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #3;
      chk("model_q",    q,    m_q);
      chk("model_qb",   qb,   ~m_q);
      chk("model_busy", busy, m_busy);
      chk("model_rise", rise, m_rise);
      chk("model_fall", fall, m_fall);
      if (lit_on) begin
         chk("lit_q",    q,    lit_q);
         chk("lit_qb",   qb,   ~lit_q);
         chk("lit_busy", busy, lit_busy);
         chk("lit_rise", rise, lit_rise);
         chk("lit_fall", fall, lit_fall);
      end
   end

   task automatic set_lit(input logic eq, input logic eb, input logic er, input logic ef);
      lit_on   = 1'b1;
      lit_q    = eq;
      lit_busy = eb;
      lit_rise = er;
      lit_fall = ef;
   endtask

   initial begin
      rst = 1'b0;
      din = 1'b1;

      // Held in reset with din high: everything stays at reset values.
      set_lit(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      din    = 1'b0;
      rst    = 1'b1;
      lit_on = 1'b0;
      repeat (6) @(negedge clk);

      // Clean rise: busy from edge 3, q and rise on edge 7.
      din = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         set_lit(k >= 7, (k >= 3) && (k <= 6), EDGE_EN && (k == 7), 1'b0);
         @(negedge clk);
      end
      lit_on = 1'b0;
      repeat (3) @(negedge clk);

      // Clean fall from q=1.
      din = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         set_lit(k < 7, (k >= 3) && (k <= 6), 1'b0, EDGE_EN && (k == 7));
         @(negedge clk);
      end
      lit_on = 1'b0;
      repeat (3) @(negedge clk);

      // Bounce: high for 3 cycles only, never accepted.
      for (int k = 1; k <= 10; k++) begin
         din = (k <= 3);
         set_lit(1'b0, (k >= 3) && (k <= 5), 1'b0, 1'b0);
         @(negedge clk);
      end
      lit_on = 1'b0;
      repeat (3) @(negedge clk);

      // Reset half a cycle after edge 4 of a rise qualification.
      din = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         set_lit(1'b0, k >= 3, 1'b0, 1'b0);
         @(negedge clk);
      end
      set_lit(1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #5  rst = 1'b0;
      #10 rst = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         set_lit(k >= 7, (k >= 3) && (k <= 6), EDGE_EN && (k == 7), 1'b0);
         @(negedge clk);
      end
      lit_on = 1'b0;

      // Random bouncy input with occasional short reset pulses.
      for (int seg = 0; seg < 500; seg++) begin
         din = ~din;
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b0;
            #5 rst = 1'b1;
         end
         repeat ($urandom_range(1, 2 * STABLE + 3)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, meaning consecutive synchronized-stable cycles required before accepting a level change; legal range 2..(2**CNT_W - 1).
REQ-002 Parameter CNT_W, default 8, meaning width of the stability counter.
REQ-003 Port clk  input  1  single clock; all flops rising-edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port din  input  1  raw asynchronous, bouncy level from a switch or pin.
REQ-006 Port q  output  1  debounced level; drives the d input of the downstream flip-flop stage.
REQ-007 Port qb  output  1  complement of q.
REQ-008 Port rise  output  1  one-cycle pulse when q goes 0->1.
REQ-009 Port fall  output  1  one-cycle pulse when q goes 1->0.
REQ-010 Port busy  output  1  high while a candidate level change is being qualified.

Function
REQ-011 din SHALL pass through a 2-flop synchronizer; only the second-stage output (d_sync) feeds any other logic.
REQ-012 FSM states SHALL be S_LOW, S_CHK_HIGH, S_HIGH and S_CHK_LOW; q=1 only in S_HIGH and S_CHK_LOW.
REQ-013 S_LOW: d_sync=1 -> S_CHK_HIGH with cnt=0; otherwise hold.
REQ-014 S_CHK_HIGH: d_sync=0 -> S_LOW with cnt=0 (bounce rejected, no pulse); d_sync=1 and cnt=STABLE_CYCLES-1 -> S_HIGH, rise=1 for that cycle; otherwise cnt+1.
REQ-015 S_HIGH and S_CHK_LOW SHALL mirror REQ-013/014 with polarities inverted, and fall replacing rise.
REQ-016 Latency: with din stable from the first sampling edge (edge 1), q SHALL change on edge STABLE_CYCLES+3 (edge 19 at default).
REQ-017 Any bounce during qualification SHALL restart qualification from cnt=0 on the next opposite transition; q SHALL never toggle on a pulse shorter than STABLE_CYCLES cycles.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-019 rise and fall SHALL never assert in the same cycle; each SHALL be registered and coincident with the q edge.
REQ-020 busy SHALL equal 1 exactly in S_CHK_HIGH and S_CHK_LOW.
REQ-021 qb SHALL equal ~q in every cycle, including during reset.

Reset
REQ-022 rst=0 SHALL immediately clear both synchronizer flops, cnt=0, state=S_LOW, q=0, qb=1, rise=0, fall=0, busy=0, independent of clk.
REQ-023 Reset asserted mid-qualification SHALL abandon the qualification; after release, qualification SHALL restart from REQ-013 with no pulse emitted.
REQ-024 If din=1 at reset release, q SHALL rise on edge STABLE_CYCLES+3 after release, with rise pulsed.

Configuration
REQ-025 Macro INPUT_DEBOUNCE_EDGE_EN: when defined, rise and fall are generated per REQ-014/015/019; when undefined, rise and fall are tied to constant 0 and their registers are not built, with q/qb/busy timing unchanged.

Structure
REQ-026 A shared package debounce_pkg SHALL hold the 2-bit state encodings (S_LOW=00, S_CHK_HIGH=01, S_HIGH=11, S_CHK_LOW=10) and the constant SYNC_STAGES=2.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff (ports clk, rst, d, q), reset to 0.

Verification (bench uses STABLE_CYCLES=4, clk period 20 ns, checks 3 ns after each posedge)
REQ-028 Reset: rst=0 at t=0, din=1 -> q=0, qb=1, rise=0, busy=0 throughout reset.
REQ-029 Clean rise: din 0->1 before edge 1, held -> busy=1 from edge 3, q=1 and rise=1 on edge 7 only, busy=0 after edge 7.
REQ-030 Bounce reject: din high for 3 cycles then low -> busy pulses, q stays 0, rise never asserts.
REQ-031 Clean fall from q=1: din 1->0 held -> q=0 and fall=1 on edge 7 after the change; qb=1.
REQ-032 Mid-qualification reset: rst=0 on edge 4 of a rise qualification for half a cycle, din held 1 -> q stays 0 until edge 7 counted from release, no extra pulses.
REQ-033 With INPUT_DEBOUNCE_EDGE_EN undefined, rerun REQ-029 -> identical q timing, rise=0 always.
